// File: rtl/ram_sdp_clr.sv
// ============================================================================
// Module   : ram_sdp_clr
// Brief    : Single-clock simple dual-port RAM with byte-lane writes, a
//            registered read port and a built-in clear engine.
//            Optional macro RAM_SDP_BYPASS_EN selects write-first forwarding
//            on same-address read/write; otherwise reads are read-first.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module ram_sdp_clr #(
    parameter int                 D_WIDTH     = 16,
    parameter int                 A_WIDTH     = 5,
    parameter logic [D_WIDTH-1:0] CLEAR_VALUE = '0
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [A_WIDTH-1:0]   address_write,
    input  logic [D_WIDTH-1:0]   data_write,
    input  logic                 write_enable,
    input  logic [D_WIDTH/8-1:0] byte_enable,
    input  logic [A_WIDTH-1:0]   address_read,
    input  logic                 read_enable,
    output logic [D_WIDTH-1:0]   data_read,
    output logic                 read_valid,
    input  logic                 init_start,
    output logic                 init_busy
);

    localparam int               DEPTH  = 2 ** A_WIDTH;
    localparam int               NBYTES = D_WIDTH / 8;
    localparam logic [A_WIDTH-1:0] c_LAST_ADDR = {A_WIDTH{1'b1}};

    typedef enum logic [0:0] {
        ST_CLEAR = 1'b0,
        ST_IDLE  = 1'b1
    } state_t;

    state_t               r_state;
    state_t               w_state_nxt;
    logic [A_WIDTH-1:0]   r_cnt;
    logic [A_WIDTH-1:0]   w_cnt_nxt;
    logic                 w_clr_wr;
    logic                 w_wr_acc;
    logic                 w_rd_acc;
    logic [D_WIDTH-1:0]   w_rd_word;
    logic [D_WIDTH-1:0]   r_data_read;
    logic                 r_read_valid;
    logic [D_WIDTH-1:0]   r_mem [DEPTH];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= ST_CLEAR;
            r_cnt   <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
        end
    end

    // init_start takes priority over any same-cycle port request in IDLE.
    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        w_clr_wr    = 1'b0;
        w_wr_acc    = 1'b0;
        w_rd_acc    = 1'b0;
        case (r_state)
            ST_CLEAR: begin
                w_clr_wr  = 1'b1;
                w_cnt_nxt = r_cnt + 1'b1;
                if (r_cnt == c_LAST_ADDR) begin
                    w_state_nxt = ST_IDLE;
                    w_cnt_nxt   = '0;
                end
            end
            ST_IDLE: begin
                if (init_start) begin
                    w_state_nxt = ST_CLEAR;
                    w_cnt_nxt   = '0;
                end else begin
                    w_wr_acc = write_enable;
                    w_rd_acc = read_enable;
                end
            end
            default: begin
                w_state_nxt = ST_CLEAR;
                w_cnt_nxt   = '0;
            end
        endcase
    end

    // Storage has no reset so it can map onto block RAM.
    always_ff @(posedge clk) begin
        if (w_clr_wr) begin
            r_mem[r_cnt] <= CLEAR_VALUE;
        end else if (w_wr_acc) begin
            for (int i = 0; i < NBYTES; i++) begin
                if (byte_enable[i]) begin
                    r_mem[address_write][8*i +: 8] <= data_write[8*i +: 8];
                end
            end
        end
    end

`ifdef RAM_SDP_BYPASS_EN
    always_comb begin
        w_rd_word = r_mem[address_read];
        if (w_wr_acc && (address_write == address_read)) begin
            for (int i = 0; i < NBYTES; i++) begin
                if (byte_enable[i]) begin
                    w_rd_word[8*i +: 8] = data_write[8*i +: 8];
                end
            end
        end
    end
`else
    always_comb begin
        w_rd_word = r_mem[address_read];
    end
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_data_read  <= '0;
            r_read_valid <= 1'b0;
        end else begin
            r_read_valid <= w_rd_acc;
            if (w_rd_acc) begin
                r_data_read <= w_rd_word;
            end
        end
    end

    assign data_read  = r_data_read;
    assign read_valid = r_read_valid;
    assign init_busy  = (r_state == ST_CLEAR);

endmodule

`default_nettype wire

// File: tb/tb_ram_sdp_clr.sv
// ============================================================================
// Module   : tb_ram_sdp_clr
// Brief    : Self-checking bench for ram_sdp_clr: directed vector table,
//            clear/reset sequences and randomized traffic against a model.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_ram_sdp_clr;

    localparam int DW    = 16;
    localparam int AW    = 5;
    localparam int NB    = 2;
    localparam int DEPTH = 32;
    localparam logic [15:0] CLR = 16'h0000;
`ifdef RAM_SDP_BYPASS_EN
    localparam logic [15:0] COLL = 16'h00A5;
`else
    localparam logic [15:0] COLL = 16'h00FF;
`endif

    logic          clk = 1'b0;
    logic          rst;
    logic [AW-1:0] address_write;
    logic [DW-1:0] data_write;
    logic          write_enable;
    logic [NB-1:0] byte_enable;
    logic [AW-1:0] address_read;
    logic          read_enable;
    logic [DW-1:0] data_read;
    logic          read_valid;
    logic          init_start;
    logic          init_busy;

    always #5 clk = ~clk;

    ram_sdp_clr #(
        .D_WIDTH    (DW),
        .A_WIDTH    (AW),
        .CLEAR_VALUE(CLR)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .address_write(address_write),
        .data_write   (data_write),
        .write_enable (write_enable),
        .byte_enable  (byte_enable),
        .address_read (address_read),
        .read_enable  (read_enable),
        .data_read    (data_read),
        .read_valid   (read_valid),
        .init_start   (init_start),
        .init_busy    (init_busy)
    );

    int checks = 0;
    int errors = 0;

    // Reference model: clear fills all words at once, then a busy countdown.
    logic [15:0] m_mem [DEPTH];
    int          m_busy;
    logic [15:0] m_dr;
    logic        m_rv;

    typedef struct {
        logic        we;
        logic [4:0]  wa;
        logic [15:0] wd;
        logic [1:0]  be;
        logic        re;
        logic [4:0]  ra;
        logic        st;
        logic [15:0] e_dr;
        logic        e_rv;
        logic        e_busy;
    } vec_t;

    vec_t vecs [13];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h expected=%h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_clear_all();
        for (int a = 0; a < DEPTH; a++) m_mem[a] = CLR;
    endtask

    task automatic model_edge();
        logic [15:0] rd;
        if (m_busy > 0) begin
            m_busy--;
            m_rv = 1'b0;
        end else if (init_start) begin
            m_busy = DEPTH;
            m_rv   = 1'b0;
            model_clear_all();
        end else begin
            if (read_enable) begin
                rd = m_mem[address_read];
`ifdef RAM_SDP_BYPASS_EN
                if (write_enable && address_write == address_read)
                    for (int i = 0; i < NB; i++)
                        if (byte_enable[i]) rd[8*i +: 8] = data_write[8*i +: 8];
`endif
                m_dr = rd;
                m_rv = 1'b1;
            end else begin
                m_rv = 1'b0;
            end
            if (write_enable)
                for (int i = 0; i < NB; i++)
                    if (byte_enable[i]) m_mem[address_write][8*i +: 8] = data_write[8*i +: 8];
        end
    endtask

    task automatic cycle(input logic we, input logic [4:0] wa, input logic [15:0] wd,
                         input logic [1:0] be, input logic re, input logic [4:0] ra,
                         input logic st, input bit cmp);
        write_enable  = we;
        address_write = wa;
        data_write    = wd;
        byte_enable   = be;
        read_enable   = re;
        address_read  = ra;
        init_start    = st;
        model_edge();
        @(posedge clk);
        #1;
        if (cmp) begin
            chk("data_read",  data_read,  m_dr);
            chk("read_valid", read_valid, m_rv);
            chk("init_busy",  init_busy,  m_busy > 0);
        end
    endtask

    task automatic do_reset();
        #2;
        rst           = 1'b1;
        write_enable  = 1'b0;
        read_enable   = 1'b0;
        init_start    = 1'b0;
        address_write = '0;
        address_read  = '0;
        data_write    = '0;
        byte_enable   = '0;
        #1;
        chk("rst_data_read",  data_read,  16'h0000);
        chk("rst_read_valid", read_valid, 1'b0);
        chk("rst_init_busy",  init_busy,  1'b1);
        m_busy = DEPTH;
        m_dr   = '0;
        m_rv   = 1'b0;
        model_clear_all();
        @(posedge clk);
        @(posedge clk);
        #1;
        rst = 1'b0;
    endtask

    task automatic count_clear(input logic re, input logic [4:0] ra);
        int n = 0;
        while (init_busy && n < 40) begin
            cycle(1'b0, 5'd0, 16'h0, 2'b00, re, ra, 1'b0, 1'b1);
            n++;
        end
        chk("clear_length", n, 32);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    initial begin
        vecs[0]  = '{1'b1, 5'd3, 16'hABCD, 2'b11, 1'b0, 5'd0, 1'b0, 16'h0000, 1'b0, 1'b0};
        vecs[1]  = '{1'b1, 5'd3, 16'h1200, 2'b10, 1'b0, 5'd0, 1'b0, 16'h0000, 1'b0, 1'b0};
        vecs[2]  = '{1'b0, 5'd0, 16'h0000, 2'b00, 1'b1, 5'd3, 1'b0, 16'h12CD, 1'b1, 1'b0};
        vecs[3]  = '{1'b1, 5'd5, 16'h00FF, 2'b11, 1'b0, 5'd0, 1'b0, 16'h12CD, 1'b0, 1'b0};
        vecs[4]  = '{1'b1, 5'd5, 16'hA5A5, 2'b01, 1'b1, 5'd5, 1'b0, COLL,     1'b1, 1'b0};
        vecs[5]  = '{1'b0, 5'd0, 16'h0000, 2'b00, 1'b1, 5'd5, 1'b0, 16'h00A5, 1'b1, 1'b0};
        vecs[6]  = '{1'b0, 5'd0, 16'h0000, 2'b00, 1'b1, 5'd3, 1'b0, 16'h12CD, 1'b1, 1'b0};
        vecs[7]  = '{1'b1, 5'd3, 16'h1111, 2'b11, 1'b0, 5'd0, 1'b0, 16'h12CD, 1'b0, 1'b0};
        vecs[8]  = '{1'b1, 5'd3, 16'h2222, 2'b01, 1'b0, 5'd0, 1'b0, 16'h12CD, 1'b0, 1'b0};
        vecs[9]  = '{1'b1, 5'd3, 16'h3333, 2'b10, 1'b0, 5'd0, 1'b0, 16'h12CD, 1'b0, 1'b0};
        vecs[10] = '{1'b1, 5'd3, 16'h4444, 2'b00, 1'b0, 5'd0, 1'b0, 16'h12CD, 1'b0, 1'b0};
        vecs[11] = '{1'b1, 5'd3, 16'h5555, 2'b01, 1'b0, 5'd0, 1'b0, 16'h12CD, 1'b0, 1'b0};
        vecs[12] = '{1'b0, 5'd0, 16'h0000, 2'b00, 1'b1, 5'd3, 1'b0, 16'h3355, 1'b1, 1'b0};

        rst = 1'b1;
        do_reset();

        // Clear after reset with a read held pending the whole time.
        count_clear(1'b1, 5'd7);
        cycle(1'b0, 5'd0, 16'h0, 2'b00, 1'b1, 5'd7, 1'b0, 1'b1);
        chk("first_read_value", data_read, 16'h0000);

        for (int v = 0; v < 13; v++) begin
            cycle(vecs[v].we, vecs[v].wa, vecs[v].wd, vecs[v].be,
                  vecs[v].re, vecs[v].ra, vecs[v].st, 1'b0);
            chk($sformatf("vec%0d_data_read", v),  data_read,  vecs[v].e_dr);
            chk($sformatf("vec%0d_read_valid", v), read_valid, vecs[v].e_rv);
            chk($sformatf("vec%0d_init_busy", v),  init_busy,  vecs[v].e_busy);
        end

        // init_start with a same-cycle write: write is dropped, everything clears.
        for (int a = 0; a < DEPTH; a++)
            cycle(1'b1, a[4:0], 16'hFFFF, 2'b11, 1'b0, 5'd0, 1'b0, 1'b1);
        cycle(1'b1, 5'd2, 16'h1234, 2'b11, 1'b0, 5'd0, 1'b1, 1'b1);
        count_clear(1'b1, 5'd2);
        for (int a = 0; a < DEPTH; a++) begin
            cycle(1'b0, 5'd0, 16'h0, 2'b00, 1'b1, a[4:0], 1'b0, 1'b1);
            if (a == 2) chk("init_addr2", data_read, 16'h0000);
        end

        // Reset during a clear restarts it from scratch.
        cycle(1'b1, 5'd9, 16'hBEEF, 2'b11, 1'b0, 5'd0, 1'b0, 1'b1);
        cycle(1'b0, 5'd0, 16'h0, 2'b00, 1'b1, 5'd9, 1'b0, 1'b1);
        cycle(1'b0, 5'd0, 16'h0, 2'b00, 1'b0, 5'd0, 1'b1, 1'b1);
        for (int k = 0; k < 10; k++)
            cycle(1'b0, 5'd0, 16'h0, 2'b00, 1'b1, 5'd9, 1'b0, 1'b1);
        do_reset();
        count_clear(1'b0, 5'd0);

        for (int k = 0; k < 400; k++) begin
            cycle($urandom_range(0, 1) == 1, 5'($urandom_range(0, 31)), 16'($urandom),
                  2'($urandom_range(0, 3)), $urandom_range(0, 1) == 1,
                  5'($urandom_range(0, 31)), $urandom_range(0, 59) == 0, 1'b1);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/ram_sdp_clr.md
# ram_sdp_clr

Single-clock simple dual-port RAM: one write port with per-byte lane enables, one read port with a read-enable and a registered read-valid flag. A built-in clear engine writes a fixed value to every word after reset or on request. It replaces ad-hoc per-block RAMs wherever storage must start from a known state and sub-word writes are needed, such as descriptor tables and small buffers.

## Interface
- D_WIDTH, 16: data width in bits; must be a multiple of 8.
- A_WIDTH, 5: address width; DEPTH = 2**A_WIDTH words.
- CLEAR_VALUE, 0: D_WIDTH-bit value written by the clear engine.

Ports:
- clk  in  1  single clock, rising edge.
- rst  in  1  reset, asynchronous, active-high.
- address_write  in  A_WIDTH  write address.
- data_write  in  D_WIDTH  write data.
- write_enable  in  1  write request.
- byte_enable  in  D_WIDTH/8  lane mask; bit i covers data bits [8i+7:8i].
- address_read  in  A_WIDTH  read address.
- read_enable  in  1  read request.
- data_read  out  D_WIDTH  registered read data.
- read_valid  out  1  data_read updated this cycle.
- init_start  in  1  request a full clear.
- init_busy  out  1  clear engine active; ports ignored.

## Operation
- Reset values: data_read=0, read_valid=0, init_busy=1, FSM=CLEAR, clear counter=0. Memory contents are undefined until the clear completes.
- FSM states:
  - CLEAR: each cycle, memory[counter] <= CLEAR_VALUE and counter increments. At counter=DEPTH-1 the FSM goes to IDLE and init_busy deasserts.
  - IDLE: normal port operation. init_start=1 moves the FSM to CLEAR with counter=0 and init_busy=1.
- Write in IDLE: when write_enable=1, each lane i with byte_enable[i]=1 is written from data_write. Other lanes keep their old contents. byte_enable=0 with write_enable=1 is a no-op.
- Read in IDLE: when read_enable=1, data_read <= memory[address_read] and read_valid <= 1. Otherwise data_read holds its value and read_valid <= 0.
- In CLEAR, write_enable, read_enable and init_start are ignored. Requests are dropped, not queued. read_valid stays 0 and data_read holds.
- Same-cycle init_start and write/read in IDLE: init_start wins. The write and the read are both dropped.
- Read and write to the same address in the same cycle: result depends on RAM_SDP_BYPASS_EN (see Configuration).
- Reset asserted mid-clear or mid-operation: outputs go to their reset values immediately, and the clear restarts from address 0 after release.
- Addresses are always in range because DEPTH = 2**A_WIDTH. The clear counter is A_WIDTH+1 bits or detects DEPTH-1 explicitly; it never wraps silently.

## Timing
- Read latency is 1 cycle: read_enable sampled at edge N gives data_read/read_valid valid after edge N, for one cycle.
- Write latency is 1 cycle: data written at edge N is visible to a read sampled at edge N+1 or later.
- Clear after reset release:
  - Clear writes occur on edges 1..DEPTH after release.
  - init_busy goes low after edge DEPTH.
  - The first accepted request is sampled at edge DEPTH+1.
- Clear via init_start:
  - init_start sampled at edge N gives init_busy=1 after edge N.
  - Clear writes occur on edges N+1..N+DEPTH.
  - init_busy goes low after edge N+DEPTH.
- init_busy is registered and is the only throttle. There is no other backpressure.

## Configuration
- RAM_SDP_BYPASS_EN defined: write-first behaviour on a same-address read+write. For each lane i:
  - byte_enable[i]=1: data_read lane takes data_write.
  - byte_enable[i]=0: data_read lane takes the old memory contents.
- RAM_SDP_BYPASS_EN undefined: read-first behaviour. data_read returns the complete pre-write word. No forwarding logic is built.

## Test plan
Defaults apply: D_WIDTH=16, A_WIDTH=5, CLEAR_VALUE=0.
- Reset clear: release rst, then hold read_enable=1 with address 7.
  - init_busy stays 1 for 32 cycles.
  - The first read_valid returns data_read=0x0000.
  - No read_valid appears while busy.
- Byte-lane write: write 0xABCD to address 3 with byte_enable=11, then 0x1200 with byte_enable=10.
  - A read of address 3 returns 0x12CD one cycle after read_enable.
- Same-address collision: memory[5]=0x00FF, then in one cycle write 0xA5A5 with byte_enable=01 and read address 5.
  - With the macro: data_read=0x00A5.
  - Without the macro: 0x00FF.
  - The next read returns 0x00A5.
- init_start: fill addresses 0..31 with 0xFFFF, then pulse init_start together with write_enable (address 2, 0x1234).
  - init_busy=1 for 32 cycles.
  - A read issued during busy is dropped (read_valid=0).
  - Afterwards all addresses, including 2, read 0x0000.
- Mid-clear reset: assert rst at clear cycle 10.
  - data_read=0, read_valid=0, init_busy=1 immediately.
  - After release, a full 32-cycle clear runs again.
- Read hold: read_enable=1 at address 3 for one cycle, then 0 for 5 cycles while writing address 3.
  - data_read holds the first value.
  - read_valid is high for exactly one cycle.
